// File: rtl/pwm_multi_pkg.sv
// Shared definitions for the multi-channel UART-driven PWM controller.
// Holds the decoder state encoding, the default frame head byte, the
// field byte counts for the default counter widths and the frame length
// for both checksum settings.
// Optional feature macro: PWM_FRAME_CHKSUM_EN (adds a trailing checksum byte).
package pwm_multi_pkg;

  // Decoder state encoding
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CH    = 3'd1;
  localparam logic [2:0] S_PER   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_NUM   = 3'd4;
  localparam logic [2:0] S_CHK   = 3'd5;
  localparam logic [2:0] S_APPLY = 3'd6;

  localparam logic [7:0] FRAME_HEAD_DEF = 8'h55;

  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned NUM_W_DEF = 16;

  // Number of frame bytes carrying a field of width w
  function automatic int unsigned bytes_of(input int unsigned w);
    return (w + 32'd7) / 32'd8;
  endfunction

  localparam int unsigned CNT_BYTES = bytes_of(CNT_W_DEF);
  localparam int unsigned NUM_BYTES = bytes_of(NUM_W_DEF);

  // HEAD + CH + PERIOD + HIGH + NUM, optionally + CHK
  localparam int unsigned FRAME_LEN_NOCHK = 2 + 2 * CNT_BYTES + NUM_BYTES;
  localparam int unsigned FRAME_LEN_CHK   = FRAME_LEN_NOCHK + 1;

`ifdef PWM_FRAME_CHKSUM_EN
  localparam int unsigned FRAME_LEN = FRAME_LEN_CHK;
`else
  localparam int unsigned FRAME_LEN = FRAME_LEN_NOCHK;
`endif

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: period counter, high-time compare and repeat counter.
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   load            one-cycle strobe: take period/high/num and restart
//   period, high    period and high time in clock cycles
//   num             repeat count, all-ones = run forever, 0 = stop
//   pwm, busy       registered waveform and generating flag
module pwm_chan #(
  parameter int unsigned CNT_W = 32,
  parameter int unsigned NUM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] high,
  input  logic [NUM_W-1:0] num,
  output logic             pwm,
  output logic             busy
);

  localparam logic [NUM_W-1:0] NUM_INF = '1;

  logic [CNT_W-1:0] per_q;
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] cnt_q;
  logic [NUM_W-1:0] rep_q;

  // Counter and output; pwm/busy track the counter value held in cnt_q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_q  <= '0;
      high_q <= '0;
      cnt_q  <= '0;
      rep_q  <= '0;
      pwm    <= 1'b0;
      busy   <= 1'b0;
    end else if (load) begin
      // A load always aborts the running waveform and starts at count 0
      per_q  <= period;
      high_q <= high;
      rep_q  <= num;
      cnt_q  <= '0;
      if (period == '0 || num == '0) begin
        pwm  <= 1'b0;
        busy <= 1'b0;
      end else begin
        pwm  <= (high != '0);
        busy <= 1'b1;
      end
    end else if (busy) begin
      if (cnt_q == CNT_W'(per_q - 1'b1)) begin
        cnt_q <= '0;
        if (rep_q != NUM_INF && rep_q == NUM_W'(1)) begin
          rep_q <= '0;
          pwm   <= 1'b0;
          busy  <= 1'b0;
        end else begin
          if (rep_q != NUM_INF) begin
            rep_q <= NUM_W'(rep_q - 1'b1);
          end
          pwm <= (high_q != '0);
        end
      end else begin
        // cnt_q < per_q - 1 here, so the increment cannot wrap
        cnt_q <= CNT_W'(cnt_q + 1'b1);
        pwm   <= (CNT_W'(cnt_q + 1'b1) < high_q);
      end
    end
  end

endmodule

// File: rtl/uart_pwm_multi_ctrl.sv
// UART command decoder driving CH_NUM independent PWM channels.
// Frame (MSB first): HEAD, CH, PERIOD, HIGH, NUM [, CHK].
// Optional feature macro: PWM_FRAME_CHKSUM_EN -- when defined a CHK byte
// (8-bit sum of CH..NUM) terminates the frame and is verified.
// Ports:
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_rx_en         one-cycle strobe, i_rx_data valid
//   i_rx_data       received byte
//   o_pwm, o_busy   per-channel waveform and generating flag
//   o_frame_ok      one-cycle pulse: frame accepted and applied
//   o_frame_err     one-cycle pulse: frame rejected or gap timeout
module uart_pwm_multi_ctrl
  import pwm_multi_pkg::*;
#(
  parameter int unsigned CH_NUM     = 4,
  parameter int unsigned CNT_W      = CNT_W_DEF,
  parameter int unsigned NUM_W      = NUM_W_DEF,
  parameter logic [7:0]  FRAME_HEAD = FRAME_HEAD_DEF,
  parameter int unsigned GAP_CYC    = 50000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rx_en,
  input  logic [7:0]        i_rx_data,
  output logic [CH_NUM-1:0] o_pwm,
  output logic [CH_NUM-1:0] o_busy,
  output logic              o_frame_ok,
  output logic              o_frame_err
);

  localparam int unsigned CNT_B = bytes_of(CNT_W);
  localparam int unsigned NUM_B = bytes_of(NUM_W);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

  logic [2:0]        state_q, state_d;
  logic [7:0]        ch_q;
  logic [CNT_W-1:0]  per_q;
  logic [CNT_W-1:0]  high_q;
  logic [NUM_W-1:0]  num_q;
  logic [7:0]        bidx_q;
  logic [GAP_W-1:0]  gap_q;
  logic [CH_NUM-1:0] load_q, load_d;
`ifdef PWM_FRAME_CHKSUM_EN
  logic [7:0]        sum_q;
`endif

  logic timeout;
  logic frame_done;
  logic frame_good;
  logic ch_valid;
  logic in_frame;

  assign ch_valid = (32'(ch_q) < CH_NUM);
  assign in_frame = (state_q != S_IDLE) && (state_q != S_APPLY);

  // Decoder state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, frame completion and per-channel load select
  always_comb begin
    state_d    = state_q;
    timeout    = 1'b0;
    frame_done = 1'b0;
    frame_good = 1'b0;
    load_d     = '0;

    if (in_frame && !i_rx_en && gap_q == GAP_W'(GAP_CYC - 1)) begin
      timeout = 1'b1;
    end

    case (state_q)
      // A head arriving during S_APPLY opens the next frame directly
      S_IDLE, S_APPLY: begin
        if (i_rx_en && i_rx_data == FRAME_HEAD) begin
          state_d = S_CH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CH: begin
        if (i_rx_en) state_d = S_PER;
      end
      S_PER: begin
        if (i_rx_en && bidx_q == 8'(CNT_B - 1)) state_d = S_HIGH;
      end
      S_HIGH: begin
        if (i_rx_en && bidx_q == 8'(CNT_B - 1)) state_d = S_NUM;
      end
      S_NUM: begin
        if (i_rx_en && bidx_q == 8'(NUM_B - 1)) begin
`ifdef PWM_FRAME_CHKSUM_EN
          state_d = S_CHK;
`else
          state_d    = S_APPLY;
          frame_done = 1'b1;
          frame_good = ch_valid;
`endif
        end
      end
`ifdef PWM_FRAME_CHKSUM_EN
      S_CHK: begin
        if (i_rx_en) begin
          state_d    = S_APPLY;
          frame_done = 1'b1;
          frame_good = ch_valid && (sum_q == i_rx_data);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    if (timeout) begin
      state_d = S_IDLE;
    end

    for (int unsigned k = 0; k < CH_NUM; k++) begin
      load_d[k] = frame_done && frame_good && (32'(ch_q) == k);
    end
  end

  // Field assembly, byte index within a field and inter-byte gap timer
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ch_q   <= '0;
      per_q  <= '0;
      high_q <= '0;
      num_q  <= '0;
      bidx_q <= '0;
      gap_q  <= '0;
`ifdef PWM_FRAME_CHKSUM_EN
      sum_q  <= '0;
`endif
    end else begin
      if (i_rx_en || !in_frame || timeout) begin
        gap_q <= '0;
      end else begin
        gap_q <= GAP_W'(gap_q + 1'b1);
      end

      if (i_rx_en) begin
        case (state_q)
          S_CH: begin
            ch_q   <= i_rx_data;
            bidx_q <= '0;
`ifdef PWM_FRAME_CHKSUM_EN
            sum_q  <= i_rx_data;
`endif
          end
          S_PER: begin
            per_q  <= CNT_W'({per_q, i_rx_data});
            bidx_q <= (bidx_q == 8'(CNT_B - 1)) ? 8'd0 : 8'(bidx_q + 8'd1);
`ifdef PWM_FRAME_CHKSUM_EN
            sum_q  <= 8'(sum_q + i_rx_data);
`endif
          end
          S_HIGH: begin
            high_q <= CNT_W'({high_q, i_rx_data});
            bidx_q <= (bidx_q == 8'(CNT_B - 1)) ? 8'd0 : 8'(bidx_q + 8'd1);
`ifdef PWM_FRAME_CHKSUM_EN
            sum_q  <= 8'(sum_q + i_rx_data);
`endif
          end
          S_NUM: begin
            num_q  <= NUM_W'({num_q, i_rx_data});
            bidx_q <= (bidx_q == 8'(NUM_B - 1)) ? 8'd0 : 8'(bidx_q + 8'd1);
`ifdef PWM_FRAME_CHKSUM_EN
            sum_q  <= 8'(sum_q + i_rx_data);
`endif
          end
          default: bidx_q <= '0;
        endcase
      end
    end
  end

  // Frame result pulses and channel load strobes, active in S_APPLY
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_ok  <= 1'b0;
      o_frame_err <= 1'b0;
      load_q      <= '0;
    end else begin
      o_frame_ok  <= frame_done && frame_good;
      o_frame_err <= timeout || (frame_done && !frame_good);
      load_q      <= load_d;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_chan
    pwm_chan #(
      .CNT_W (CNT_W),
      .NUM_W (NUM_W)
    ) u_chan (
      .clk    (i_clk),
      .rst_n  (i_rst_n),
      .load   (load_q[k]),
      .period (per_q),
      .high   (high_q),
      .num    (num_q),
      .pwm    (o_pwm[k]),
      .busy   (o_busy[k])
    );
  end

endmodule
